// File: rtl/key_led_driver.sv
// key_led_driver: per-key sync, debounce, note pulses, LED release tail and lowest-index active encoder
// Define LED_BLINK_EN to blink the LED from hold_cnt[BLINK_SHIFT] during the release tail.
module key_led_driver #(
  parameter int NUM_KEYS = 7,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES = 12500000,
  parameter int BLINK_SHIFT = 21,
  localparam int IW = NUM_KEYS > 1 ? $clog2(NUM_KEYS) : 1
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] switches,
  output logic [NUM_KEYS-1:0] leds,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] note_on,
  output logic [NUM_KEYS-1:0] note_off,
  output logic                active_valid,
  output logic [IW-1:0]       active_idx
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1) < 1 ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1) < 1 ? 1 : $clog2(HOLD_CYCLES + 1);
`ifdef LED_BLINK_EN
  localparam bit SOLID = 1'b0;
`else
  localparam bit SOLID = 1'b1;
`endif
  typedef enum logic [1:0] {IDLE, ON, HOLD} state_t;
  logic [NUM_KEYS-1:0] s1, s2;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= switches;
      s2 <= s1;
    end
  for (genvar g = 0; g < NUM_KEYS; g++) begin : ch
    state_t st;
    logic [DW-1:0] dc;
    logic [HW-1:0] hc, hn;
    logic ks, non, noff, led, flip, hold_led;
    assign flip = (s2[g] != ks) && (dc == DW'(DEBOUNCE_CYCLES - 1));
    // next hold count: reload on ON exit, otherwise the decremented value
    assign hn = (st == ON) ? HW'(HOLD_CYCLES - 1) : hc - 1'b1;
    assign hold_led = SOLID | 1'(hn >> BLINK_SHIFT);
    always_ff @(posedge CLOCK_50 or posedge reset)
      if (reset) begin
        st <= IDLE;
        dc <= '0;
        hc <= '0;
        ks <= 1'b0;
        non <= 1'b0;
        noff <= 1'b0;
        led <= 1'b0;
      end else begin
        dc <= (s2[g] == ks || flip) ? '0 : dc + 1'b1;
        ks <= ks ^ flip;
        non <= flip & ~ks;
        noff <= flip & ks;
        case (st)
          IDLE: if (non) begin
            st <= ON;
            led <= 1'b1;
          end
          ON: if (noff) begin
            st <= (HOLD_CYCLES == 0) ? IDLE : HOLD;
            hc <= hn;
            led <= (HOLD_CYCLES != 0) && hold_led;
          end
          HOLD: if (non) begin
            st <= ON;
            led <= 1'b1;
          end else if (hc == '0) begin
            st <= IDLE;
            led <= 1'b0;
          end else begin
            hc <= hn;
            led <= hold_led;
          end
          default: begin
            st <= IDLE;
            led <= 1'b0;
          end
        endcase
      end
    assign key_state[g] = ks;
    assign note_on[g] = non;
    assign note_off[g] = noff;
    assign leds[g] = led;
  end
  assign active_valid = |key_state;
  always_comb begin
    active_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (key_state[i]) active_idx = IW'(i);
  end
endmodule

// File: tb/tb_key_led_driver.sv
// tb_key_led_driver: randomized and directed checks of key_led_driver against a window/event-time reference model
module tb_key_led_driver;
  localparam int NK = 7, DEB = 4, HOLD = 10, BS = 1;
  logic clk = 1'b0, reset = 1'b1;
  logic [NK-1:0] switches = '0, leds, key_state, note_on, note_off;
  logic active_valid;
  logic [2:0] active_idx;
  int n_cmp = 0, n_bad = 0, t = 0;
  logic [NK-1:0] md1, md2, mks, mon, moff, mled;
  logic [DEB-1:0] mwin [NK];
  int last_on [NK], last_off [NK];
  logic [31:0] got;

  key_led_driver #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .BLINK_SHIFT(BS)) dut (
    .CLOCK_50(clk), .reset(reset), .switches(switches), .leds(leds), .key_state(key_state),
    .note_on(note_on), .note_off(note_off), .active_valid(active_valid), .active_idx(active_idx));

  always #5 clk = ~clk;
  assign got = {leds, key_state, note_on, note_off, active_valid, active_idx};

  task automatic model_reset();
    md1 = '0; md2 = '0; mks = '0; mon = '0; moff = '0; mled = '0;
    for (int i = 0; i < NK; i++) begin
      mwin[i] = '0;
      last_on[i] = -100000;
      last_off[i] = -100000;
    end
  endtask

  // A key flips once its last DEB synced samples all disagree with it; the LED is
  // lit while pressed since an earlier cycle, or within HOLD cycles after release.
  task automatic tick();
    @(posedge clk);
    t++;
    if (reset) model_reset();
    else begin
      for (int i = 0; i < NK; i++) begin
        logic f, hb;
        mwin[i] = {mwin[i][DEB-2:0], md2[i]};
        f = (mwin[i] == {DEB{~mks[i]}});
`ifdef LED_BLINK_EN
        hb = (((last_off[i] + HOLD - t) >> BS) & 1) != 0;
`else
        hb = 1'b1;
`endif
        mled[i] = (last_on[i] > last_off[i]) || (t <= last_off[i] + HOLD && hb);
        mon[i] = f & ~mks[i];
        moff[i] = f & mks[i];
        if (mon[i]) last_on[i] = t;
        if (moff[i]) last_off[i] = t;
        mks[i] = mks[i] ^ f;
      end
      md2 = md1;
      md1 = switches;
    end
    #1;
  endtask

  function automatic logic [31:0] exp_v();
    logic [2:0] idx = '0;
    for (int i = NK - 1; i >= 0; i--) if (mks[i]) idx = 3'(i);
    return {mled, mks, mon, moff, |mks, idx};
  endfunction

  task automatic settle(input int n);
    switches = '0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    int n = 0;
    switches = '1;
    repeat (3) begin
      tick();
      n_cmp++;
      if (got !== exp_v()) begin n_bad++; $display("FAIL reset_hold got=%h exp=%h", got, exp_v()); end
    end
    reset = 1'b0;
    while (leds !== '1 && n < 40) begin
      tick();
      n++;
      n_cmp++;
      if (got !== exp_v()) begin n_bad++; $display("FAIL reset_release t=%0d got=%h exp=%h", t, got, exp_v()); end
    end
    n_cmp++;
    if (n !== 7) begin n_bad++; $display("FAIL reset_led_latency got=%0d exp=7", n); end
    repeat (3) tick();
    #2 reset = 1'b1;
    #1 n_cmp++;
    if (got !== 32'h0) begin n_bad++; $display("FAIL reset_async got=%h exp=0", got); end
    repeat (2) begin
      tick();
      n_cmp++;
      if (got !== exp_v()) begin n_bad++; $display("FAIL reset_abort got=%h exp=%h", got, exp_v()); end
    end
    switches = '0;
    reset = 1'b0;
    repeat (DEB + 4) begin
      tick();
      n_cmp++;
      if (got !== exp_v()) begin n_bad++; $display("FAIL reset_quiet got=%h exp=%h", got, exp_v()); end
    end
  endtask

  task automatic test_clean_press();
    settle(20);
    switches[3] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_cmp++;
      if (got !== exp_v()) begin n_bad++; $display("FAIL press c=%0d got=%h exp=%h", c, got, exp_v()); end
      if (c == 5) begin
        n_cmp++;
        if (key_state[3] !== 1'b0) begin n_bad++; $display("FAIL press_early got=%b exp=0", key_state[3]); end
      end
      if (c == 6) begin
        n_cmp++;
        if ({note_on[3], active_valid, active_idx} !== 5'b1_1_011) begin
          n_bad++; $display("FAIL press_edge got=%b exp=11011", {note_on[3], active_valid, active_idx});
        end
      end
      if (c == 7) begin
        n_cmp++;
        if ({leds[3], note_on[3]} !== 2'b10) begin n_bad++; $display("FAIL press_led got=%b exp=10", {leds[3], note_on[3]}); end
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 40; c++) begin
      switches[0] = (c % 4) != 3;
      tick();
      n_cmp++;
      if (got !== exp_v() || {key_state[0], note_on[0], leds[0]} !== 3'b000) begin
        n_bad++; $display("FAIL bounce c=%0d got=%h exp=%h", c, got, exp_v());
      end
    end
    switches[0] = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if ({key_state[0], note_on[0]} !== 2'b11 || got !== exp_v()) begin
      n_bad++; $display("FAIL bounce_accept got=%h exp=%h", got, exp_v());
    end
  endtask

  task automatic test_release_hold();
    int k = -1, lit = 0, gap = 0, seen = 0, n = 0;
    switches[3] = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      n_cmp++;
      if (got !== exp_v()) begin n_bad++; $display("FAIL release c=%0d got=%h exp=%h", c, got, exp_v()); end
      if (note_off[3]) k = c;
      if (k >= 0 && leds[3]) lit++;
    end
`ifndef LED_BLINK_EN
    n_cmp++;
    if (lit !== HOLD + 1) begin n_bad++; $display("FAIL release_tail got=%0d exp=%0d", lit, HOLD + 1); end
`endif
    switches[3] = 1'b1;
    repeat (10) tick();
    switches[3] = 1'b0;
    while (!note_off[3] && n < 12) begin tick(); n++; end
    n_cmp++;
    if (n >= 12) begin n_bad++; $display("FAIL retrig_wait got=timeout exp=note_off"); end
    repeat (3) tick();
    switches[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_cmp++;
      if (got !== exp_v()) begin n_bad++; $display("FAIL retrig c=%0d got=%h exp=%h", c, got, exp_v()); end
      if (note_on[3]) seen++;
      if (!leds[3]) gap++;
    end
    n_cmp++;
`ifdef LED_BLINK_EN
    gap = 0;
`endif
    if (seen !== 1 || gap !== 0) begin n_bad++; $display("FAIL retrig_nogap got=on%0d/gap%0d exp=on1/gap0", seen, gap); end
  endtask

  task automatic test_priority();
    settle(20);
    switches = 7'b0100100;
    repeat (10) tick();
    n_cmp++;
    if ({active_valid, active_idx} !== 4'b1_010 || got !== exp_v()) begin
      n_bad++; $display("FAIL prio_both got=%h exp=%h", got, exp_v());
    end
    switches[2] = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (active_idx !== 3'd2) begin n_bad++; $display("FAIL prio_still2 got=%0d exp=2", active_idx); end
    tick();
    n_cmp++;
    if (active_idx !== 3'd5 || got !== exp_v()) begin n_bad++; $display("FAIL prio_5 got=%0d exp=5", active_idx); end
    switches[5] = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if ({active_valid, active_idx} !== 4'b0 || got !== exp_v()) begin
      n_bad++; $display("FAIL prio_none got=%b exp=0000", {active_valid, active_idx});
    end
  endtask

  task automatic test_random();
    settle(20);
    for (int c = 0; c < 1200; c++) begin
      int rate = ((c / 60) % 2) ? 3 : 25;
      for (int i = 0; i < NK; i++)
        if ($urandom_range(rate - 1) == 0) switches[i] = ~switches[i];
      if (c == 700) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      tick();
      n_cmp++;
      if (got !== exp_v()) begin n_bad++; $display("FAIL random c=%0d got=%h exp=%h", c, got, exp_v()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_hold();
    test_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
